// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter
//    Iterative AES-128 decryptor (FIPS-197 InvCipher), one round per clock.
//    The final round key is produced by forward expansion of the cipher key.
//    The schedule is then walked backwards while the state is decrypted.
//    The last (cipher key, round-10 key) pair is cached, so a repeated key
//    skips the expansion phase.
//
//    Ports:
//       clk        rising-edge clock
//       rst_n      synchronous active-low reset
//       in_valid   ciphertext/key presented
//       in_ready   block can accept a job (registered, high only in IDLE)
//       data_in    ciphertext, bit 127 = byte 0
//       key_in     cipher key (round-0 key), same byte order
//       out_valid  plaintext valid (registered)
//       out_ready  consumer accepts plaintext
//       data_out   plaintext (registered)
//
//    Latency from the accepting edge to the edge that raises out_valid:
//    11 cycles on a key-cache hit, 21 cycles on a miss.

module aes128_decrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      KEY_EXP = 2'd1,
      ROUND   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         state_q;
   logic [3:0]     rc_q;
   logic [127:0]   s_q;
   logic [127:0]   k_q;
   logic [127:0]   orig_key_q;
   logic           cache_valid_q;
   logic [127:0]   cache_key_q;
   logic [127:0]   cache_rk_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic [127:0]   data_out_q;

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------
   function automatic logic [7:0] rcon_f(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] m11(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] m13(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] m14(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3),
              m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3),
              m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3),
              m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3)};
   endfunction

   function automatic logic [127:0] inv_mix_cols(input logic [127:0] x);
      logic [127:0] y;
      y = 128'h0;
      for (int c = 0; c < 4; c++) begin
         y[127-32*c -: 32] = inv_mix_col(x[127-32*c -: 32]);
      end
      return y;
   endfunction

   // ---------------------------------------------------------------------
   // Key path: one SubWord unit shared by forward and inverse schedule
   // ---------------------------------------------------------------------
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  iw1, iw2, iw3;
   logic [31:0]  sub_src;
   logic [31:0]  rot_w;
   logic [31:0]  sub_w;
   logic [7:0]   rcon_sel;
   logic [31:0]  fw0, fw1, fw2, fw3;
   logic [127:0] fwd_key;
   logic [127:0] inv_key;

   assign {w0, w1, w2, w3} = k_q;
   assign iw3 = w3 ^ w2;
   assign iw2 = w2 ^ w1;
   assign iw1 = w1 ^ w0;

   // Forward step works from w3; backward step needs the recovered w3'.
   assign sub_src  = (state_q == KEY_EXP) ? w3 : iw3;
   assign rot_w    = {sub_src[23:0], sub_src[31:24]};
   // Forward step for round rc uses Rcon[rc]; undoing round rc+1 uses Rcon[rc+1].
   assign rcon_sel = (state_q == KEY_EXP) ? rcon_f(rc_q) : rcon_f(rc_q + 4'd1);

   for (genvar i = 0; i < 4; i++) begin : g_key_sbox
      sbox u_sbox (
         .a_i (rot_w[31-8*i -: 8]),
         .y_o (sub_w[31-8*i -: 8])
      );
   end

   assign fw0     = w0 ^ sub_w ^ {rcon_sel, 24'h000000};
   assign fw1     = w1 ^ fw0;
   assign fw2     = w2 ^ fw1;
   assign fw3     = w3 ^ fw2;
   assign fwd_key = {fw0, fw1, fw2, fw3};
   assign inv_key = {w0 ^ sub_w ^ {rcon_sel, 24'h000000}, iw1, iw2, iw3};

   // ---------------------------------------------------------------------
   // Data path: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
   // ---------------------------------------------------------------------
   logic [127:0] isr;
   logic [127:0] isb;
   logic [127:0] ark;
   logic [127:0] imc;

   // Byte (row r, column c) sits at index r + 4c; row r rotates right by r.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign isr[127-8*(r+4*c) -: 8] = s_q[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_data_sbox
      inv_sbox u_inv_sbox (
         .a_i (isr[127-8*i -: 8]),
         .y_o (isb[127-8*i -: 8])
      );
   end

   assign ark = isb ^ inv_key;
   assign imc = inv_mix_cols(ark);

   // ---------------------------------------------------------------------
   // Control FSM with registered handshake outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rc_q          <= 4'd0;
         s_q           <= 128'h0;
         k_q           <= 128'h0;
         orig_key_q    <= 128'h0;
         cache_valid_q <= 1'b0;
         cache_key_q   <= 128'h0;
         cache_rk_q    <= 128'h0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         data_out_q    <= 128'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  s_q        <= data_in;
                  orig_key_q <= key_in;
                  in_ready_q <= 1'b0;
                  if (cache_valid_q && (key_in == cache_key_q)) begin
                     k_q     <= cache_rk_q;
                     rc_q    <= 4'd10;
                     state_q <= ROUND;
                  end else begin
                     k_q     <= key_in;
                     rc_q    <= 4'd1;
                     state_q <= KEY_EXP;
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            KEY_EXP: begin
               k_q <= fwd_key;
               if (rc_q == 4'd10) begin
                  cache_key_q   <= orig_key_q;
                  cache_rk_q    <= fwd_key;
                  cache_valid_q <= 1'b1;
                  state_q       <= ROUND;
               end else begin
                  rc_q <= rc_q + 4'd1;
               end
            end
            ROUND: begin
               if (rc_q == 4'd10) begin
                  s_q  <= s_q ^ k_q;
                  rc_q <= 4'd9;
               end else if (rc_q != 4'd0) begin
                  s_q  <= imc;
                  k_q  <= inv_key;
                  rc_q <= rc_q - 4'd1;
               end else begin
                  // Final round has no InvMixColumns; k becomes the cipher key.
                  s_q         <= ark;
                  k_q         <= inv_key;
                  data_out_q  <= ark;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  out_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               rc_q        <= 4'd0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;

endmodule

// sbox
//    Forward AES S-box: multiplicative inverse in GF(2^8) followed by the
//    affine transform.  Ports: a_i byte in, y_o substituted byte.
module sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         else      p = p;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 = a^-1 for a != 0, and maps 0 to 0 as required.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (i != 0) r = gf_mul(r, a);
         else        r = r;
      end
      return r;
   endfunction

   logic [7:0] b;

   assign b   = gf_inv(a_i);
   assign y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;

endmodule

// inv_sbox
//    Inverse AES S-box: inverse affine transform followed by the GF(2^8)
//    multiplicative inverse.  Ports: a_i byte in, y_o substituted byte.
module inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         else      p = p;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (i != 0) r = gf_mul(r, a);
         else        r = r;
      end
      return r;
   endfunction

   logic [7:0] b;

   assign b   = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
   assign y_o = gf_inv(b);

endmodule
